// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO size defaults and width-generic Gray/binary helpers
package fifo_pkg;
   localparam int FIFO_WD       = 32;
   localparam int FIFO_MEM_SIZE = 16;
   localparam int GRAY_MAXW     = 64;
   typedef logic [GRAY_MAXW-1:0] gvec_t;
   function automatic gvec_t width_mask(input int w);
      gvec_t m;
      m = '0;
      for (int i = 0; i < GRAY_MAXW; i++) m[i] = (i < w);
      return m;
   endfunction
   function automatic gvec_t bin2gray(input gvec_t b, input int w);
      gvec_t bm;
      bm = b & width_mask(w);
      return bm ^ (bm >> 1);
   endfunction
   function automatic gvec_t gray2bin(input gvec_t g, input int w);
      gvec_t gm, b;
      gm = g & width_mask(w);
      b = '0;
      b[GRAY_MAXW-1] = gm[GRAY_MAXW-1];
      for (int i = GRAY_MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ gm[i];
      return b;
   endfunction
endpackage

// File: rtl/fifo_skid2.sv
// fifo_skid2: two-entry valid/ready output buffer with a registered head entry
module fifo_skid2 #(
   parameter int WD = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [WD-1:0] din,
   input  logic          pop,
   output logic [1:0]    cnt,
   output logic [WD-1:0] dout,
   output logic          valid
);
   logic [WD-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]    cnt_q, cnt_d;
   // head refills from tail (or din when tail is empty); tail takes din only behind a kept head
   always_comb begin
      head_d = (pop && cnt_q == 2'd2) ? tail_q :
               (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? din : head_q;
      tail_d = (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop))) ? din : tail_q;
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
   end
   // buffer state, cleared so a reset discards anything held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end
   assign cnt   = cnt_q;
   assign dout  = head_q;
   assign valid = (cnt_q != 2'd0);
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain FIFO controller feeding a valid/ready stream from mem_fifo
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int WD       = FIFO_WD,
   parameter int mem_size = FIFO_MEM_SIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [mem_size:0]   wr_ptr_gray,
   output logic [mem_size:0]   rd_ptr_gray,
   output logic                re,
   output logic [mem_size-1:0] re_point,
   input  logic [WD-1:0]       rdata,
   output logic [WD-1:0]       m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                empty,
   output logic [mem_size:0]   level
);
   localparam int PW = mem_size + 1;
   logic [PW-1:0] wq1_q, wq2_q, rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d, wr_bin;
   logic          inflight_q, pop;
   logic [1:0]    cnt;
   logic [2:0]    occ;
   // words buffered plus in flight after this pop must stay below two before another read issues
   always_comb begin
      wr_bin    = PW'(gray2bin(gvec_t'(wq2_q), PW));
      level     = wr_bin - rd_bin_q;
      empty     = (level == '0);
      pop       = m_valid && m_ready;
      occ       = {1'b0, cnt} + {2'b0, inflight_q} - {2'b0, pop};
      re        = !empty && (occ < 3'd2);
      rd_bin_d  = rd_bin_q + PW'(re);
      rd_gray_d = PW'(bin2gray(gvec_t'(rd_bin_d), PW));
   end
   // write-pointer synchronizer, read pointers and the one-cycle RAM latency marker
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wq1_q      <= '0;
         wq2_q      <= '0;
         rd_bin_q   <= '0;
         rd_gray_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         wq1_q      <= wr_ptr_gray;
         wq2_q      <= wq1_q;
         rd_bin_q   <= rd_bin_d;
         rd_gray_q  <= rd_gray_d;
         inflight_q <= re;
      end
   end
   assign rd_ptr_gray = rd_gray_q;
   assign re_point    = rd_bin_q[mem_size-1:0];
   fifo_skid2 #(.WD(WD)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight_q),
      .din   (rdata),
      .pop   (pop),
      .cnt   (cnt),
      .dout  (m_data),
      .valid (m_valid)
   );
endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for `mem_fifo`, running in the read clock domain. It synchronizes the Gray-coded write pointer and keeps the binary and Gray read pointers. It drives `re`/`re_point` into `mem_fifo` and captures the one-cycle-latency `rdata` into a 2-entry output buffer. It presents a valid/ready stream to the downstream consumer with full throughput under back-pressure.

## Interface
Parameters:
- `WD`, 32, data width; equals `mem_fifo.WD`.
- `mem_size`, 16, address bits; equals `mem_fifo.mem_size`; pointers are `mem_size+1` bits.

Ports:
- `clk`  in  1  read-domain clock; same net as `mem_fifo.clk_re`.
- `rst`  in  1  asynchronous, active-high reset. The top level drives `mem_fifo.rst` with `~rst`.
- `wr_ptr_gray`  in  mem_size+1  Gray write pointer from the write domain, asynchronous to `clk`.
- `rd_ptr_gray`  out  mem_size+1  registered Gray read pointer, sent to the write domain.
- `re`  out  1  read strobe to `mem_fifo.re`.
- `re_point`  out  mem_size  read address to `mem_fifo.re_point`.
- `rdata`  in  WD  `mem_fifo.rdata`; valid the cycle after `re`.
- `m_data`  out  WD  output stream data.
- `m_valid`  out  1  output stream valid.
- `m_ready`  in  1  output stream ready.
- `empty`  out  1  no unread words in RAM from the read side's view.
- `level`  out  mem_size+1  words in RAM not yet read (excludes the buffer and in-flight words).

## Operation
- Synchronizer:
  - `wq1 <= wr_ptr_gray; wq2 <= wq1`.
  - `wr_bin = gray2bin(wq2)`.
- Read pointer:
  - `rd_bin` (mem_size+1 bits) increments on `re`.
  - `rd_ptr_gray <= bin2gray(rd_bin_next)`.
  - `re_point = rd_bin[mem_size-1:0]`.
- Level and empty:
  - `level = wr_bin - rd_bin`, modulo 2^(mem_size+1); maximum 2^mem_size.
  - `empty = (level == 0)`.
- Pop: `pop = m_valid && m_ready`.
- Issue rule: `re = !empty && (cnt + inflight - pop) < 2`.
  - `cnt` is the buffer occupancy (0..2).
  - `inflight` is a flop, `inflight <= re`.
  - This is a combinational path from `m_ready` to `re`, by design.
- Capture: when `inflight==1`, `rdata` is pushed into the buffer that cycle. The buffer never overflows, by the issue rule.
- Output buffer:
  - `m_valid = (cnt != 0)`; `m_data` is the head entry, driven from a register.
  - Simultaneous push and pop keeps `cnt` unchanged, and order is preserved.
  - While `m_valid && !m_ready`, `m_data` must hold stable.
- Wrap-around: the pointers roll over naturally at 2^(mem_size+1). The MSB difference distinguishes full from empty for the write side.
- Reset mid-operation:
  - All state clears immediately; buffered and in-flight data are discarded.
  - The write domain must be reset in the same event.

## Timing
- Reset values:
  - `wq1`, `wq2`, `rd_bin`, `rd_ptr_gray`, `inflight`, `cnt`, and buffer entries are all 0.
  - Outputs `re=0`, `re_point=0`, `m_valid=0`, `m_data=0`, `empty=1`, `level=0`.
- Write-pointer latency: `wr_ptr_gray` changes before edge 1. `wq2` updates at edge 2, so `empty` falls and `re=1` after edge 2.
- Read latency: `mem_fifo` registers `rdata` at edge 3, and `m_valid` rises after edge 4.
- Minimum latency is therefore 4 `clk` edges from write-pointer update to `m_valid`.
- `rd_ptr_gray` reflects a read one edge after the `re` that caused it.
- Throughput: with `m_ready` held high and data available, one word per cycle indefinitely.
- Back-pressure: after `m_ready` deasserts, at most 2 more words enter the buffer, then `re` stays 0.

## Structure
- Package `fifo_pkg` holds:
  - `bin2gray` and `gray2bin` as width-generic functions (loop up to a fixed maximum width, masked);
  - the shared `mem_size`/`WD` defaults, used by `mem_fifo` and the write controller too.
- Sub-module `fifo_skid2` is the 2-entry valid/ready output buffer:
  - inputs `push`, `din`, `pop`;
  - outputs `cnt`, `dout`, `valid`.
- The synchronizer, pointers and issue logic stay in `fifo_rd_ctrl`.

## Test plan
- Reset, then step `wr_ptr_gray` from 0 to `bin2gray(1)` with RAM[0]=0xA5A5A5A5 → `re` pulses once with `re_point=0`; `m_valid` rises 4 edges after the change with `m_data=0xA5A5A5A5`; `rd_ptr_gray=1`; `empty=1` afterwards.
- 8 words 0..7 written, `m_ready=1` → 8 consecutive `m_valid` cycles with data 0..7; `re` is high for 8 consecutive cycles.
- 8 words available, `m_ready=0` → exactly 2 `re` pulses, `cnt=2`, `m_data=0` stable. Raising `m_ready` then delivers 0..7 in order with no gaps.
- `mem_size=2`, 20 words streamed with random `m_ready` → in-order data 0..19 across pointer wrap; `level` never exceeds 4; `rd_ptr_gray` changes by one bit per step.
- Assert `rst` while `cnt=2` and `inflight=1` → next sample shows `m_valid=0`, `re=0`, `rd_ptr_gray=0`, `empty=1`, `level=0`.
- `wr_ptr_gray` jumps by 4 in one step (legal Gray sequence applied over 4 write-domain cycles) → `level` steps monotonically to 4; no spurious reads beyond 4.
